// File: rtl/con_ebus_arb_if.sv
// EBUS arbitration bundle: per-master request/release strobes in, grant and
// watchdog status out. The master side drives requests, the slave side is the arbiter.
interface con_ebus_arb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] rel;
  logic            err_clr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  owner;
  logic            busy;
  logic            timeout_err;
  logic [IDW-1:0]  err_id;

  modport master (
    output req, rel, err_clr,
    input  grant, owner, busy, timeout_err, err_id
  );

  modport slave (
    input  req, rel, err_clr,
    output grant, owner, busy, timeout_err, err_id
  );
endinterface

// File: rtl/con_ebus_arb.sv
// con_ebus_arb: NREQ-way EBUS ownership arbiter with a registered one-hot grant,
// a turnaround gap between owners and a hold watchdog that latches a sticky error.
module con_ebus_arb #(
  parameter int unsigned NREQ    = 4,
  parameter bit          RR_MODE = 1'b0,
  parameter int unsigned DEAD    = 1,
  parameter logic [15:0] TIMEOUT = 16'd255,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input logic           clk,
  input logic           rst_n,
  con_ebus_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWNED = 2'd1,
    S_TURN  = 2'd2
  } state_e;

  localparam logic [15:0]     HOLD_LAST = TIMEOUT - 16'd1;
  localparam logic [15:0]     TURN_LAST = 16'(DEAD - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ - 1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic            busy_q, busy_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [15:0]     hold_q, hold_d;
  logic [15:0]     turn_q, turn_d;
  logic            err_q, err_d;
  logic [IDW-1:0]  err_id_q, err_id_d;

  logic            lo_vld_s, hi_vld_s, win_vld_s, wdog_s;
  logic [IDW-1:0]  lo_idx_s, hi_idx_s, win_idx_s;

  // Winner search: lowest set request overall, and lowest set request above the RR pointer.
  always_comb begin
    lo_vld_s = 1'b0;
    lo_idx_s = '0;
    hi_vld_s = 1'b0;
    hi_idx_s = '0;
    for (int j = int'(NREQ) - 1; j >= 0; j--) begin
      if (bus.req[j]) begin
        lo_vld_s = 1'b1;
        lo_idx_s = IDW'(j);
        if (j > int'(ptr_q)) begin
          hi_vld_s = 1'b1;
          hi_idx_s = IDW'(j);
        end else begin
          hi_vld_s = hi_vld_s;
        end
      end else begin
        lo_vld_s = lo_vld_s;
      end
    end
    win_vld_s = lo_vld_s;
    if (RR_MODE && hi_vld_s) begin
      win_idx_s = hi_idx_s;
    end else begin
      win_idx_s = lo_idx_s;
    end
  end

  // Ownership FSM next state, grant outputs, watchdog and sticky error.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    turn_d   = turn_q;
    err_d    = err_q;
    err_id_d = err_id_q;
    wdog_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld_s) begin
          state_d = S_OWNED;
          grant_d = ONE_HOT0 << win_idx_s;
          owner_d = win_idx_s;
          busy_d  = 1'b1;
          ptr_d   = win_idx_s;
          hold_d  = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OWNED: begin
        // An owner release beats a watchdog expiry on the same edge.
        if (bus.rel[owner_q] || !bus.req[owner_q]) begin
          state_d = S_TURN;
          grant_d = '0;
          busy_d  = 1'b0;
          turn_d  = 16'd0;
        end else if ((TIMEOUT != 16'd0) && (hold_q == HOLD_LAST)) begin
          wdog_s  = 1'b1;
          state_d = S_TURN;
          grant_d = '0;
          busy_d  = 1'b0;
          turn_d  = 16'd0;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      S_TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = S_IDLE;
        end else begin
          turn_d = turn_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
    // A timeout on the clear edge still records the error.
    if (bus.err_clr) begin
      err_d    = 1'b0;
      err_id_d = '0;
    end else begin
      err_d = err_d;
    end
    if (wdog_s) begin
      err_d    = 1'b1;
      err_id_d = owner_q;
    end else begin
      err_id_d = err_id_d;
    end
  end

  // State and output registers; reset drops the grant without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
      ptr_q    <= IDW'(NREQ - 1);
      hold_q   <= 16'd0;
      turn_q   <= 16'd0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
  assign bus.err_id      = err_id_q;

endmodule

// File: tb/tb_con_ebus_arb.sv
// Bench for con_ebus_arb: a fixed-priority and a round-robin instance share stimulus
// and are compared against a cycle-level ownership model plus directed vectors.
module tb_con_ebus_arb;

  localparam int DEAD = 1;
  localparam int TMO  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_s = 4'b0000;
  logic [3:0] rel_s = 4'b0000;
  logic       clr_s = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  con_ebus_arb_if #(.NREQ(4)) if_fix ();
  con_ebus_arb_if #(.NREQ(4)) if_rr ();

  assign if_fix.req     = req_s;
  assign if_fix.rel     = rel_s;
  assign if_fix.err_clr = clr_s;
  assign if_rr.req      = req_s;
  assign if_rr.rel      = rel_s;
  assign if_rr.err_clr  = clr_s;

  con_ebus_arb #(.NREQ(4), .RR_MODE(1'b0), .DEAD(DEAD), .TIMEOUT(16'd8)) u_fix (
    .clk(clk), .rst_n(rst_n), .bus(if_fix));
  con_ebus_arb #(.NREQ(4), .RR_MODE(1'b1), .DEAD(DEAD), .TIMEOUT(16'd8)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(if_rr));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required $finish earlier", $time);
    $fatal(1);
  end

  // Ownership model: [0] fixed priority, [1] round robin.
  int m_busy[2], m_owner[2], m_held[2], m_gap[2], m_ptr[2], m_err[2], m_errid[2];

  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] g_fix;
    logic [3:0] g_rr;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int k, input logic [3:0] r);
    int idx;
    pick = -1;
    if (k == 0) begin
      for (int i = 3; i >= 0; i--) if (r[i]) pick = i;
    end else begin
      for (int d = 4; d >= 1; d--) begin
        idx = (m_ptr[k] + d) % 4;
        if (r[idx]) pick = idx;
      end
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_owner[k] = 0; m_held[k] = 0; m_gap[k] = DEAD + 1;
      m_ptr[k] = 3; m_err[k] = 0; m_errid[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int w;
    bit to;
    to = 1'b0;
    if (m_busy[k] != 0) begin
      m_held[k]++;
      if (rel_s[m_owner[k]] || !req_s[m_owner[k]]) begin
        m_busy[k] = 0; m_gap[k] = 0;
      end else if (m_held[k] >= TMO) begin
        m_busy[k] = 0; m_gap[k] = 0; to = 1'b1;
      end
    end else begin
      if (m_gap[k] < DEAD + 1) m_gap[k]++;
      if (m_gap[k] >= DEAD + 1) begin
        w = pick(k, req_s);
        if (w >= 0) begin
          m_busy[k] = 1; m_owner[k] = w; m_held[k] = 0; m_ptr[k] = w;
        end
      end
    end
    if (clr_s) begin m_err[k] = 0; m_errid[k] = 0; end
    if (to) begin m_err[k] = 1; m_errid[k] = m_owner[k]; end
  endtask

  task automatic check_dut(input int k, input logic [3:0] g, input logic [1:0] o,
                           input logic b, input logic e, input logic [1:0] eid);
    logic [3:0] eg;
    eg = (m_busy[k] != 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
    check($sformatf("model_grant[%0d]", k), 32'(g), 32'(eg));
    check($sformatf("model_busy[%0d]", k), 32'(b), 32'(m_busy[k]));
    if (m_busy[k] != 0) check($sformatf("model_owner[%0d]", k), 32'(o), 32'(m_owner[k]));
    check($sformatf("model_err[%0d]", k), 32'(e), 32'(m_err[k]));
    check($sformatf("model_err_id[%0d]", k), 32'(eid), 32'(m_errid[k]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_dut(0, if_fix.grant, if_fix.owner, if_fix.busy, if_fix.timeout_err, if_fix.err_id);
    check_dut(1, if_rr.grant, if_rr.owner, if_rr.busy, if_rr.timeout_err, if_rr.err_id);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant_fix"}, 32'(if_fix.grant), 32'd0);
    check({tag, "_grant_rr"}, 32'(if_rr.grant), 32'd0);
    check({tag, "_busy"}, 32'(if_fix.busy | if_rr.busy), 32'd0);
    check({tag, "_owner"}, 32'(if_fix.owner | if_rr.owner), 32'd0);
    check({tag, "_err"}, 32'(if_fix.timeout_err | if_rr.timeout_err), 32'd0);
    check({tag, "_err_id"}, 32'(if_fix.err_id | if_rr.err_id), 32'd0);
  endtask

  task automatic apply_reset();
    req_s = 4'b0000; rel_s = 4'b0000; clr_s = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    tick();
    while (if_fix.grant == 4'b0000 && n < 10) begin
      tick();
      n++;
    end
    check("wait_grant_bound", 32'(if_fix.grant != 4'b0000), 32'd1);
  endtask

  int cnt, idle, idx;

  initial begin
    tbl[0]  = '{4'b1010, 4'b0000, 4'b0010, 4'b0010};
    tbl[1]  = '{4'b1000, 4'b0010, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b1000, 4'b0000, 4'b1000, 4'b1000};
    tbl[4]  = '{4'b1000, 4'b0000, 4'b1000, 4'b1000};
    tbl[5]  = '{4'b1001, 4'b0000, 4'b1000, 4'b1000};
    tbl[6]  = '{4'b1001, 4'b1000, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0001};
    tbl[9]  = '{4'b0001, 4'b1000, 4'b0001, 4'b0001};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};

    apply_reset();
    for (int i = 0; i < 11; i++) begin
      req_s = tbl[i].req;
      rel_s = tbl[i].rel;
      tick();
      check($sformatf("tbl_fix[%0d]", i), 32'(if_fix.grant), 32'(tbl[i].g_fix));
      check($sformatf("tbl_rr[%0d]", i), 32'(if_rr.grant), 32'(tbl[i].g_rr));
    end
    rel_s = 4'b0000;

    // Round robin: every owner releases after three cycles of grant.
    apply_reset();
    req_s = 4'b1111;
    idle = 0;
    for (int n = 0; n < 5; n++) begin
      cnt = 0;
      tick();
      while (if_rr.grant == 4'b0000 && cnt < 10) begin
        idle++; cnt++;
        tick();
      end
      idx = -1;
      for (int b = 0; b < 4; b++) if (if_rr.grant[b]) idx = b;
      check($sformatf("rr_order[%0d]", n), 32'(idx), 32'(n % 4));
      if (n > 0) check($sformatf("rr_idle[%0d]", n), 32'(idle), 32'd2);
      tick();
      tick();
      rel_s = if_rr.grant;
      tick();
      rel_s = 4'b0000;
      idle = 1;
    end

    // Watchdog: master 2 never releases.
    apply_reset();
    req_s = 4'b0100;
    wait_grant();
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if_fix.grant[2]) cnt++;
      else break;
    end
    check("wdog_hold_cycles", 32'(cnt), 32'd8);
    check("wdog_err", 32'(if_fix.timeout_err), 32'd1);
    check("wdog_err_id", 32'(if_fix.err_id), 32'd2);
    req_s = 4'b0000;
    clr_s = 1'b1;
    tick();
    clr_s = 1'b0;
    check("errclr_err", 32'(if_fix.timeout_err), 32'd0);
    check("errclr_err_id", 32'(if_fix.err_id), 32'd0);

    // Release on the expiry edge wins over the watchdog.
    req_s = 4'b0100;
    wait_grant();
    repeat (7) tick();
    rel_s = 4'b0100;
    tick();
    rel_s = 4'b0000;
    check("rel_vs_wdog_err", 32'(if_fix.timeout_err), 32'd0);
    check("rel_vs_wdog_grant", 32'(if_fix.grant), 32'd0);

    // Timeout on the ERR_CLR edge still sets the flag.
    wait_grant();
    repeat (7) tick();
    clr_s = 1'b1;
    tick();
    clr_s = 1'b0;
    check("clr_vs_wdog_err", 32'(if_fix.timeout_err), 32'd1);
    check("clr_vs_wdog_err_id", 32'(if_fix.err_id), 32'd2);

    // Asynchronous reset in the middle of a grant.
    apply_reset();
    req_s = 4'b0100;
    wait_grant();
    tick();
    check("pre_reset_grant", 32'(if_fix.grant), 32'h4);
    rst_n = 1'b0;
    #1;
    check("async_rst_grant_fix", 32'(if_fix.grant), 32'd0);
    check("async_rst_grant_rr", 32'(if_rr.grant), 32'd0);
    check("async_rst_busy", 32'(if_fix.busy | if_rr.busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    req_s = 4'b1111;
    tick();
    check("post_reset_rr_first", 32'(if_rr.grant), 32'h1);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req_s = 4'($urandom);
      rel_s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      clr_s = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
